fetch_sp_block: RTL and testbench

Reader counterpart of the 8x8 S write-back block. It fetches one 8x8 block of pre-IDCT coefficients (S', one signed 16-bit value per SRAM word) from the S' segment of external SRAM and writes them, sign-extended to 32 bits, into port A of the embedded S' dual-port RAM. It sits between the SRAM controller and the IDCT (C·S') datapath and is started by the top-level milestone FSM once per block.

---
 rtl/fetch_sp_pkg.sv | 34 +++
 rtl/fetch_sp_addr_gen.sv | 33 +++
 rtl/fetch_sp_block.sv | 135 +++++++++++++
 tb/tb_fetch_sp_block.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sp_pkg.sv
// Shared types and constants for the S'/S block transfer engines that sit
// between the SRAM controller and the IDCT datapath.
package fetch_sp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_DRAIN2 = 3'd3,
        ST_DONE   = 3'd4
    } xfer_state_e;

    // Segment select: Y_finished = 0 addresses luma, 1 addresses chroma.
    typedef enum logic {
        SEG_Y  = 1'b0,
        SEG_UV = 1'b1
    } seg_e;

    localparam logic [17:0] SP_BASE   = 18'd76800;
    localparam logic [17:0] UV_OFFSET = 18'd76800;

    // Row strides as shift pairs: 320 = 256 + 64, 160 = 128 + 32.
    localparam int Y_SH_HI  = 8;
    localparam int Y_SH_LO  = 6;
    localparam int UV_SH_HI = 7;
    localparam int UV_SH_LO = 5;

    localparam logic [5:0] LAST_IDX = 6'd63;

    function automatic logic [31:0] sext16(input logic [15:0] d);
        return {{16{d[15]}}, d};
    endfunction

endpackage

// File: rtl/fetch_sp_addr_gen.sv
// Combinational SRAM word address for one coefficient of an 8x8 block:
// segment base + (row + row_init) * stride + col + col_init, modulo 2^18.
module fetch_sp_addr_gen
    import fetch_sp_pkg::*;
(
    input  logic [2:0]  ra_i,
    input  logic [2:0]  ca_i,
    input  logic [8:0]  ra_init_i,
    input  logic [8:0]  ca_init_i,
    input  logic        seg_i,
    output logic [17:0] addr_o
);

    logic [17:0] row;
    logic [17:0] col;
    logic [17:0] row_off;
    logic [17:0] base;

    // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
    always_comb begin
        row = {9'd0, ra_init_i} + {15'd0, ra_i};
        col = {9'd0, ca_init_i} + {15'd0, ca_i};
        if (seg_i == SEG_UV) begin
            row_off = (row << UV_SH_HI) + (row << UV_SH_LO);
            base    = SP_BASE + UV_OFFSET;
        end else begin
            row_off = (row << Y_SH_HI) + (row << Y_SH_LO);
            base    = SP_BASE;
        end
        addr_o = base + row_off + col;
    end

endmodule

// File: rtl/fetch_sp_block.sv
// Fetches one 8x8 block of signed 16-bit S' coefficients from SRAM and writes
// them sign-extended into port A of the S' RAM; one pulse on finish per block.
module fetch_sp_block
    import fetch_sp_pkg::*;
(
    input  logic        Clock_50,
    input  logic        Resetn,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [6:0]  Address_Sp_a,
    output logic [31:0] Write_data_Sp_a,
    output logic        Write_en_Sp_a,
    input  logic [8:0]  RA_init,
    input  logic [8:0]  CA_init,
    input  logic        start,
    output logic        finish,
    input  logic        Y_finished
);

    xfer_state_e state_q;
    logic [5:0]  rd_cnt_q;
    logic [5:0]  wr_cnt_q;
    logic [1:0]  cap_pipe_q;
    logic [8:0]  ra_init_q;
    logic [8:0]  ca_init_q;
    seg_e        seg_q;
    logic [17:0] sram_addr_q;
    logic [6:0]  sp_addr_q;
    logic [31:0] sp_data_q;
    logic        sp_we_q;
    logic        finish_q;

    logic        launch;
    logic        issuing;
    logic [5:0]  idx_sel;
    logic [8:0]  ra_init_sel;
    logic [8:0]  ca_init_sel;
    logic        seg_sel;
    logic [17:0] addr_d;

    // On the launch edge the inits are not latched yet, so address 0 is
    // built from the live inputs; afterwards only the latched copies count.
    always_comb begin
        launch      = (state_q == ST_IDLE) && start;
        issuing     = launch || (state_q == ST_ISSUE);
        idx_sel     = rd_cnt_q;
        ra_init_sel = ra_init_q;
        ca_init_sel = ca_init_q;
        seg_sel     = seg_q;
        if (launch) begin
            idx_sel     = 6'd0;
            ra_init_sel = RA_init;
            ca_init_sel = CA_init;
            seg_sel     = Y_finished;
        end
    end

    fetch_sp_addr_gen u_addr_gen (
        .ra_i      (idx_sel[5:3]),
        .ca_i      (idx_sel[2:0]),
        .ra_init_i (ra_init_sel),
        .ca_init_i (ca_init_sel),
        .seg_i     (seg_sel),
        .addr_o    (addr_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            cap_pipe_q  <= '0;
            ra_init_q   <= '0;
            ca_init_q   <= '0;
            seg_q       <= SEG_Y;
            sram_addr_q <= '0;
            sp_addr_q   <= '0;
            sp_data_q   <= '0;
            sp_we_q     <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            // Read data returns two edges after its address is issued.
            cap_pipe_q <= {cap_pipe_q[0], issuing};
            finish_q   <= 1'b0;

            if (issuing) begin
                sram_addr_q <= addr_d;
            end

            if (cap_pipe_q[1]) begin
                sp_addr_q <= {1'b0, wr_cnt_q};
                sp_data_q <= sext16(SRAM_read_data);
                sp_we_q   <= 1'b1;
                wr_cnt_q  <= wr_cnt_q + 6'd1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ra_init_q <= RA_init;
                        ca_init_q <= CA_init;
                        seg_q     <= seg_e'(Y_finished);
                        rd_cnt_q  <= 6'd1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rd_cnt_q <= rd_cnt_q + 6'd1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_q <= ST_DRAIN1;
                    end
                end
                ST_DRAIN1: state_q <= ST_DRAIN2;
                ST_DRAIN2: state_q <= ST_DONE;
                ST_DONE: begin
                    sp_we_q  <= 1'b0;
                    finish_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SRAM_address    = sram_addr_q;
    assign SRAM_we_n       = 1'b1;
    assign Address_Sp_a    = sp_addr_q;
    assign Write_data_Sp_a = sp_data_q;
    assign Write_en_Sp_a   = sp_we_q;
    assign finish          = finish_q;

endmodule

// File: tb/tb_fetch_sp_block.sv
// Directed bench for fetch_sp_block: SRAM model with 2-cycle read latency,
// scoreboard of expected S' RAM writes, cycle-exact finish/enable checks.
module tb_fetch_sp_block;

    logic        Clock_50;
    logic        Resetn;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n;
    logic [6:0]  Address_Sp_a;
    logic [31:0] Write_data_Sp_a;
    logic        Write_en_Sp_a;
    logic [8:0]  RA_init;
    logic [8:0]  CA_init;
    logic        start;
    logic        finish;
    logic        Y_finished;

    fetch_sp_block dut (
        .Clock_50        (Clock_50),
        .Resetn          (Resetn),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_we_n       (SRAM_we_n),
        .Address_Sp_a    (Address_Sp_a),
        .Write_data_Sp_a (Write_data_Sp_a),
        .Write_en_Sp_a   (Write_en_Sp_a),
        .RA_init         (RA_init),
        .CA_init         (CA_init),
        .start           (start),
        .finish          (finish),
        .Y_finished      (Y_finished)
    );

    initial Clock_50 = 1'b0;
    always #5 Clock_50 = ~Clock_50;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_item_t;

    wr_item_t    sb[$];
    int          errors = 0;
    int          checks = 0;
    int          wr_seen = 0;
    int          fin_cnt = 0;
    int          cyc;
    logic [17:0] neg_addr = 18'h3FFFF;
    logic [17:0] obs_first;
    logic [17:0] obs_last;
    logic [31:0] tb_ram [64];
    logic [31:0] ram_copy [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sram_fn(input logic [17:0] a);
        return (a == neg_addr) ? 16'h8001 : a[15:0];
    endfunction

    // Reference address, written with plain multiplies.
    function automatic logic [17:0] model_addr(input int k, input int ri, input int ci, input logic y);
        int a;
        a = 76800 + (y ? 76800 : 0) + ((k / 8) + ri) * (y ? 160 : 320) + (k % 8) + ci;
        return 18'(a);
    endfunction

    // SRAM: data for the address registered at edge n is visible from edge n+1,
    // so the DUT samples it at edge n+2.
    always @(posedge Clock_50) SRAM_read_data <= sram_fn(SRAM_address);

    always @(negedge Clock_50) begin
        if (finish) fin_cnt++;
        if (Resetn && Write_en_Sp_a) begin
            wr_item_t it;
            check("sram_we_n_high", {31'd0, SRAM_we_n}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_write", {25'd0, Address_Sp_a}, 32'h7F);
            end else begin
                it = sb.pop_front();
                check("sp_addr", {25'd0, Address_Sp_a}, {25'd0, it.addr});
                check("sp_data", Write_data_Sp_a, it.data);
            end
            tb_ram[Address_Sp_a[5:0]] = Write_data_Sp_a;
            wr_seen++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sram_addr"}, {14'd0, SRAM_address}, 32'd0);
        check({tag, "_we_n"},      {31'd0, SRAM_we_n}, 32'd1);
        check({tag, "_sp_addr"},   {25'd0, Address_Sp_a}, 32'd0);
        check({tag, "_sp_data"},   Write_data_Sp_a, 32'd0);
        check({tag, "_sp_we"},     {31'd0, Write_en_Sp_a}, 32'd0);
        check({tag, "_finish"},    {31'd0, finish}, 32'd0);
    endtask

    // One block transfer. pulse_a/pulse_b: edges at which a stray start is
    // sampled (-1 = none); abort_at: edge at which Resetn is asserted (-1 = none).
    task automatic run_block(input int ri, input int ci, input logic y,
                             input int pulse_a, input int pulse_b, input int abort_at);
        wr_item_t it;
        int fin_before;
        @(negedge Clock_50);
        RA_init    = 9'(ri);
        CA_init    = 9'(ci);
        Y_finished = y;
        for (int k = 0; k < 64; k++) begin
            it.addr = 7'(k);
            it.data = {{16{sram_fn(model_addr(k, ri, ci, y))[15]}}, sram_fn(model_addr(k, ri, ci, y))};
            sb.push_back(it);
        end
        wr_seen    = 0;
        fin_before = fin_cnt;
        start      = 1'b1;
        @(posedge Clock_50);
        #1;
        cyc   = 0;
        start = 1'b0;
        // Scramble the inputs: the transfer must use the values latched at E0.
        RA_init    = ~RA_init;
        CA_init    = ~CA_init;
        Y_finished = ~Y_finished;
        obs_first  = SRAM_address;
        check("first_addr_model", {14'd0, obs_first}, {14'd0, model_addr(0, ri, ci, y)});
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clock_50);
            #1;
            cyc   = n;
            start = (n == pulse_a - 1 || n == pulse_b - 1);
            if (n == abort_at) begin
                Resetn = 1'b0;
                #1;
                check_reset_outputs("abort");
                sb.delete();
                @(negedge Clock_50);
                Resetn = 1'b1;
                return;
            end
            if (n == 1) check("we_low_e1", {31'd0, Write_en_Sp_a}, 32'd0);
            if (n == 2) check("we_high_e2", {31'd0, Write_en_Sp_a}, 32'd1);
            if (n == 63) obs_last = SRAM_address;
            if (finish) break;
        end
        start = 1'b0;
        check("finish_at_e66", cyc, 32'd66);
        check("we_low_e66", {31'd0, Write_en_Sp_a}, 32'd0);
        check("last_addr_model", {14'd0, obs_last}, {14'd0, model_addr(63, ri, ci, y)});
        @(posedge Clock_50);
        #1;
        check("finish_low_e67", {31'd0, finish}, 32'd0);
        check("write_count", wr_seen, 32'd64);
        check("scoreboard_empty", sb.size(), 32'd0);
        repeat (3) @(posedge Clock_50);
        #1;
        check("one_finish", fin_cnt - fin_before, 32'd1);
        check("sram_addr_holds", {14'd0, SRAM_address}, {14'd0, obs_last});
    endtask

    initial begin
        Resetn     = 1'b0;
        start      = 1'b0;
        RA_init    = '0;
        CA_init    = '0;
        Y_finished = 1'b0;
        repeat (3) @(posedge Clock_50);
        #1;
        check_reset_outputs("reset");
        @(negedge Clock_50);
        Resetn = 1'b1;

        // Y block at origin; row 1 starts one Y row (320 words) further on.
        run_block(0, 0, 1'b0, -1, -1, -1);
        check("y0_first", {14'd0, obs_first}, 32'd76800);
        check("y0_ram8", tb_ram[8], 32'h0000_2D40);
        check("y0_ram63", tb_ram[63], {16'd0, 16'(76800 + 7 * 320 + 7)});

        // Negative coefficient at index 5.
        neg_addr = 18'd76805;
        run_block(0, 0, 1'b0, -1, -1, -1);
        check("neg_ram5", tb_ram[5], 32'hFFFF_8001);
        check("neg_ram4", tb_ram[4], 32'h0000_2C04);
        neg_addr = 18'h3FFFF;

        // Chroma block.
        run_block(8, 16, 1'b1, -1, -1, -1);
        check("uv_first", {14'd0, obs_first}, 32'd154896);
        check("uv_last", {14'd0, obs_last}, 32'd156023);

        // Bottom-right Y block reaches the end of the Y segment exactly.
        run_block(232, 312, 1'b0, -1, -1, -1);
        check("ylast_first", {14'd0, obs_first}, 32'd151352);
        check("ylast_last", {14'd0, obs_last}, 32'd153599);

        // Stray starts mid-transfer are ignored; a rerun gives the same RAM image.
        run_block(3, 5, 1'b0, 10, 40, -1);
        for (int i = 0; i < 64; i++) ram_copy[i] = tb_ram[i];
        for (int i = 0; i < 64; i++) tb_ram[i] = 32'hDEAD_BEEF;
        run_block(3, 5, 1'b0, -1, -1, -1);
        begin
            int diffs = 0;
            for (int i = 0; i < 64; i++) if (tb_ram[i] !== ram_copy[i]) diffs++;
            check("rerun_identical", diffs, 32'd0);
        end

        // Reset in the middle of a transfer, then a full clean block.
        run_block(1, 2, 1'b1, -1, -1, 30);
        for (int i = 0; i < 64; i++) tb_ram[i] = 32'hDEAD_BEEF;
        run_block(5, 7, 1'b1, -1, -1, -1);
        check("post_abort_ram0", tb_ram[0], {16'd0, 16'(153600 + 5 * 160 + 7)});
        check("post_abort_ram63", tb_ram[63], {16'd0, 16'(153600 + 12 * 160 + 14)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
